// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the ALU-side common data bus arbiter and its picker.
package cdb_arbiter_pkg;
    localparam int   TAG_W_DEF    = 4;
    localparam int   DATA_W_DEF   = 32;
    localparam int   ROB_SIZE_DEF = 15;
    localparam int   ZERO_ROB     = 0;
    localparam logic TRUE         = 1'b1;
    localparam logic FALSE        = 1'b0;
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module cdb_arbiter_rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_idx
);
    logic w_found;
    int   w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = FALSE;
        w_j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = (int'(i_ptr) + k) % N_REQ;
            if (!w_found && i_req[w_j]) begin
                w_found      = TRUE;
                o_grant[w_j] = 1'b1;
                o_idx        = PTR_W'(w_j);
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per execution unit, one broadcast per cycle.
// Define CDB_AGE_PRIORITY_EN to grant the oldest ROB entry instead of round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ROB_SIZE = ROB_SIZE_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    in_flush,
    input  logic [N_REQ-1:0]        in_valid,
    output logic [N_REQ-1:0]        out_ready,
    input  logic [N_REQ*TAG_W-1:0]  in_tag,
    input  logic [N_REQ*DATA_W-1:0] in_value,
    input  logic [N_REQ-1:0]        in_isjump,
    input  logic [N_REQ*DATA_W-1:0] in_jump_addr,
    input  logic [TAG_W-1:0]        in_rob_head,
    output logic [TAG_W-1:0]        out_cdb_rob_tag,
    output logic [DATA_W-1:0]       out_cdb_value,
    output logic                    out_cdb_isjump,
    output logic [DATA_W-1:0]       out_cdb_jump_addr,
    output logic                    out_busy
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic              r_slot_vld  [N_REQ];
    logic [TAG_W-1:0]  r_slot_tag  [N_REQ];
    logic [DATA_W-1:0] r_slot_val  [N_REQ];
    logic              r_slot_jmp  [N_REQ];
    logic [DATA_W-1:0] r_slot_addr [N_REQ];
    logic [PTR_W-1:0]  r_ptr;

    logic [N_REQ-1:0]  w_slot_vld;
    logic [N_REQ-1:0]  w_grant;
    logic [PTR_W-1:0]  w_win_idx;
    logic              w_any;
    logic              w_advance;

    assign w_advance = ena & ~in_flush;
    assign w_any     = |w_slot_vld;
    assign out_busy  = w_any;

`ifdef CDB_AGE_PRIORITY_EN
    logic [TAG_W:0] w_age;
    logic [TAG_W:0] w_best;
    logic           w_found;

    // Age is distance from the ROB head, modulo the ROB's 1..ROB_SIZE tag space.
    always_comb begin
        w_grant   = '0;
        w_win_idx = '0;
        w_age     = '0;
        w_best    = '0;
        w_found   = FALSE;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_slot_vld[i]) begin
                if (r_slot_tag[i] >= in_rob_head)
                    w_age = {1'b0, r_slot_tag[i]} - {1'b0, in_rob_head};
                else
                    w_age = {1'b0, r_slot_tag[i]} + (TAG_W+1)'(ROB_SIZE) - {1'b0, in_rob_head};
                if (!w_found || w_age < w_best) begin
                    w_found   = TRUE;
                    w_best    = w_age;
                    w_win_idx = PTR_W'(i);
                end
            end
        end
        if (w_found)
            w_grant[w_win_idx] = 1'b1;
    end
`else
    logic              w_unused_head;
    logic [31:0]       w_unused_rob_size;
    assign w_unused_head     = ^in_rob_head;
    assign w_unused_rob_size = 32'(ROB_SIZE);

    cdb_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .i_req   (w_slot_vld),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx)
    );
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slot
            assign w_slot_vld[gi] = r_slot_vld[gi];
            // A slot being granted this cycle can take its next result at the same edge.
            assign out_ready[gi]  = w_advance & (~r_slot_vld[gi] | w_grant[gi]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slot_vld[gi]  <= 1'b0;
                    r_slot_tag[gi]  <= '0;
                    r_slot_val[gi]  <= '0;
                    r_slot_jmp[gi]  <= 1'b0;
                    r_slot_addr[gi] <= '0;
                end else if (ena) begin
                    if (in_flush) begin
                        r_slot_vld[gi] <= 1'b0;
                    end else if (in_valid[gi] && out_ready[gi] &&
                                 in_tag[gi*TAG_W +: TAG_W] != TAG_W'(ZERO_ROB)) begin
                        r_slot_vld[gi]  <= 1'b1;
                        r_slot_tag[gi]  <= in_tag[gi*TAG_W +: TAG_W];
                        r_slot_val[gi]  <= in_value[gi*DATA_W +: DATA_W];
                        r_slot_jmp[gi]  <= in_isjump[gi];
                        r_slot_addr[gi] <= in_jump_addr[gi*DATA_W +: DATA_W];
                    end else if (w_grant[gi]) begin
                        r_slot_vld[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr             <= '0;
            out_cdb_rob_tag   <= '0;
            out_cdb_value     <= '0;
            out_cdb_isjump    <= 1'b0;
            out_cdb_jump_addr <= '0;
        end else if (ena) begin
            if (in_flush || !w_any) begin
                out_cdb_rob_tag   <= '0;
                out_cdb_value     <= '0;
                out_cdb_isjump    <= 1'b0;
                out_cdb_jump_addr <= '0;
            end else begin
                out_cdb_rob_tag   <= r_slot_tag[w_win_idx];
                out_cdb_value     <= r_slot_val[w_win_idx];
                out_cdb_isjump    <= r_slot_jmp[w_win_idx];
                out_cdb_jump_addr <= r_slot_addr[w_win_idx];
                r_ptr             <= (w_win_idx == PTR_W'(N_REQ-1)) ? '0 : w_win_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a slot/queue reference model.
module tb_cdb_arbiter;
    localparam int N  = 3;
    localparam int TW = 4;
    localparam int DW = 32;
    localparam int RS = 15;

    logic clk = 1'b0;
    logic rst, ena, in_flush;
    logic [N-1:0]    in_valid, out_ready, in_isjump;
    logic [N*TW-1:0] in_tag;
    logic [N*DW-1:0] in_value, in_jump_addr;
    logic [TW-1:0]   in_rob_head, out_cdb_rob_tag;
    logic [DW-1:0]   out_cdb_value, out_cdb_jump_addr;
    logic            out_cdb_isjump, out_busy;

    always #5 clk = ~clk;

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW), .ROB_SIZE(RS)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_flush(in_flush),
        .in_valid(in_valid), .out_ready(out_ready), .in_tag(in_tag),
        .in_value(in_value), .in_isjump(in_isjump), .in_jump_addr(in_jump_addr),
        .in_rob_head(in_rob_head), .out_cdb_rob_tag(out_cdb_rob_tag),
        .out_cdb_value(out_cdb_value), .out_cdb_isjump(out_cdb_isjump),
        .out_cdb_jump_addr(out_cdb_jump_addr), .out_busy(out_busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one pending result per unit plus the last broadcast.
    logic          m_vld  [N];
    logic [TW-1:0] m_tag  [N];
    logic [DW-1:0] m_val  [N];
    logic          m_jmp  [N];
    logic [DW-1:0] m_addr [N];
    int            m_ptr;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_val, e_addr;
    logic          e_jmp;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pick();
        int w = -1;
`ifdef CDB_AGE_PRIORITY_EN
        int best = 1 << 30;
        for (int i = 0; i < N; i++) begin
            if (m_vld[i]) begin
                int t = int'(m_tag[i]);
                int h = int'(in_rob_head);
                int age = (t >= h) ? t - h : t + RS - h;
                if (age < best) begin
                    best = age;
                    w = i;
                end
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (w < 0 && m_vld[j]) w = j;
        end
`endif
        return w;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        e_tag = '0; e_val = '0; e_jmp = 1'b0; e_addr = '0;
    endtask

    task automatic clear_inputs();
        in_valid = '0; in_tag = '0; in_value = '0; in_isjump = '0;
        in_jump_addr = '0; in_flush = 1'b0; ena = 1'b1;
    endtask

    task automatic set_unit(input int i, input logic [TW-1:0] tag, input logic [DW-1:0] val,
                            input logic jmp, input logic [DW-1:0] addr);
        in_valid[i] = 1'b1;
        in_tag[i*TW +: TW] = tag;
        in_value[i*DW +: DW] = val;
        in_isjump[i] = jmp;
        in_jump_addr[i*DW +: DW] = addr;
    endtask

    // One clock: check combinational ready, advance model at the edge, check outputs.
    task automatic step();
        int w;
        logic [N-1:0] rdy;
        #1;
        w = pick();
        for (int i = 0; i < N; i++) rdy[i] = ena && !in_flush && (!m_vld[i] || i == w);
        check_eq("ready", 64'(out_ready), 64'(rdy));
        @(posedge clk);
        if (ena) begin
            if (in_flush) begin
                model_clear();
            end else begin
                if (w >= 0) begin
                    e_tag = m_tag[w]; e_val = m_val[w]; e_jmp = m_jmp[w]; e_addr = m_addr[w];
                    m_vld[w] = 1'b0;
                    m_ptr = (w + 1) % N;
                end else begin
                    e_tag = '0; e_val = '0; e_jmp = 1'b0; e_addr = '0;
                end
                for (int i = 0; i < N; i++) begin
                    if (in_valid[i] && rdy[i] && in_tag[i*TW +: TW] != 0) begin
                        m_vld[i]  = 1'b1;
                        m_tag[i]  = in_tag[i*TW +: TW];
                        m_val[i]  = in_value[i*DW +: DW];
                        m_jmp[i]  = in_isjump[i];
                        m_addr[i] = in_jump_addr[i*DW +: DW];
                    end
                end
            end
        end
        #1;
        check_eq("cdb_tag", 64'(out_cdb_rob_tag), 64'(e_tag));
        check_eq("cdb_value", 64'(out_cdb_value), 64'(e_val));
        check_eq("cdb_isjump", 64'(out_cdb_isjump), 64'(e_jmp));
        check_eq("cdb_addr", 64'(out_cdb_jump_addr), 64'(e_addr));
        check_eq("busy", 64'(out_busy), 64'(m_vld[0] | m_vld[1] | m_vld[2]));
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        m_ptr = 0;
        check_eq("rst_tag", 64'(out_cdb_rob_tag), 64'(0));
        check_eq("rst_value", 64'(out_cdb_value), 64'(0));
        check_eq("rst_isjump", 64'(out_cdb_isjump), 64'(0));
        check_eq("rst_addr", 64'(out_cdb_jump_addr), 64'(0));
        check_eq("rst_busy", 64'(out_busy), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_at;
        in_rob_head = 4'd1;
        do_reset();

        // Single unit, value 0x1234
        set_unit(0, 4'd3, 32'h1234, 1'b0, 32'h0);
        step();
        clear_inputs();
        step();
        check_eq("single_tag", 64'(out_cdb_rob_tag), 64'd3);
        check_eq("single_value", 64'(out_cdb_value), 64'h1234);
        step();
        check_eq("single_idle", 64'(out_cdb_rob_tag), 64'd0);

        // Contention from pointer 0
        do_reset();
        set_unit(0, 4'd1, 32'h11, 1'b0, 32'h0);
        set_unit(1, 4'd2, 32'h22, 1'b1, 32'h200);
        set_unit(2, 4'd3, 32'h33, 1'b0, 32'h0);
        step();
        clear_inputs();
        step(); check_eq("cont_first", 64'(out_cdb_rob_tag), 64'd1);
        step(); check_eq("cont_second", 64'(out_cdb_rob_tag), 64'd2);
        check_eq("cont_jump_addr", 64'(out_cdb_jump_addr), 64'h200);
        step(); check_eq("cont_third", 64'(out_cdb_rob_tag), 64'd3);
        step(); check_eq("cont_idle", 64'(out_cdb_rob_tag), 64'd0);

        // Fairness: unit0 streams, unit1 sends once
        do_reset();
        seen_at = -1;
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            set_unit(0, TW'(4 + c), 32'(c), 1'b0, 32'h0);
            if (c == 0) set_unit(1, 4'd9, 32'h99, 1'b0, 32'h0);
            step();
            if (out_cdb_rob_tag == 4'd9 && seen_at < 0) seen_at = c;
        end
        check_eq("fair_tag9_within_2", 64'(seen_at >= 1 && seen_at <= 2), 64'd1);

        // Flush with full slots; flush also beats a same-cycle capture
        do_reset();
        set_unit(0, 4'd5, 32'h5, 1'b0, 32'h0);
        set_unit(1, 4'd6, 32'h6, 1'b0, 32'h0);
        set_unit(2, 4'd7, 32'h7, 1'b0, 32'h0);
        step();
        set_unit(0, 4'd8, 32'h8, 1'b0, 32'h0);
        in_flush = 1'b1;
        step();
        check_eq("flush_tag", 64'(out_cdb_rob_tag), 64'd0);
        check_eq("flush_busy", 64'(out_busy), 64'd0);
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("flush_no_stale", 64'(out_cdb_rob_tag), 64'd0);
        end

        // Tag 0 is accepted and discarded
        do_reset();
        set_unit(2, 4'd0, 32'hdead, 1'b1, 32'hbeef);
        step();
        clear_inputs();
        step();
        check_eq("tag0_no_bcast", 64'(out_cdb_rob_tag), 64'd0);
        check_eq("tag0_busy", 64'(out_busy), 64'd0);

        // ena low holds slots, pointer and CDB
        do_reset();
        set_unit(0, 4'd1, 32'h1, 1'b0, 32'h0);
        set_unit(1, 4'd2, 32'h2, 1'b0, 32'h0);
        set_unit(2, 4'd3, 32'h3, 1'b0, 32'h0);
        step();
        clear_inputs();
        step(); check_eq("ena_first", 64'(out_cdb_rob_tag), 64'd1);
        ena = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("ena_hold_tag", 64'(out_cdb_rob_tag), 64'd1);
            check_eq("ena_hold_busy", 64'(out_busy), 64'd1);
        end
        ena = 1'b1;
        step(); check_eq("ena_resume_2", 64'(out_cdb_rob_tag), 64'd2);
        step(); check_eq("ena_resume_3", 64'(out_cdb_rob_tag), 64'd3);

`ifdef CDB_AGE_PRIORITY_EN
        do_reset();
        in_rob_head = 4'd14;
        set_unit(0, 4'd2, 32'h2, 1'b0, 32'h0);
        set_unit(1, 4'd15, 32'hf, 1'b0, 32'h0);
        step();
        clear_inputs();
        step(); check_eq("age_first_15", 64'(out_cdb_rob_tag), 64'd15);
        step(); check_eq("age_then_2", 64'(out_cdb_rob_tag), 64'd2);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            ena = ($urandom_range(0, 9) != 0);
            in_flush = ena && ($urandom_range(0, 24) == 0);
            in_rob_head = TW'($urandom_range(1, RS));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_unit(i, TW'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), $urandom);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single ALU-side common data bus (tag/value/isjump/jump_addr broadcast into the reorder buffer and reservation stations) among N execution units. Each unit gets a one-entry holding slot. A round-robin arbiter selects one occupied slot per cycle and drives it onto a registered CDB output. Sits between the functional units and the ROB/RS broadcast inputs; misbranch flush empties all slots.

Parameters:
N_REQ, 3, number of requesting execution units (2..8)
TAG_W, 4, ROB tag width; tag 0 means "no broadcast"
DATA_W, 32, value and jump-address width
ROB_SIZE, 15, highest valid ROB tag (tags 1..ROB_SIZE); used only by the optional feature

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ena  in  1  global enable; when low, all state holds and in_ready is 0
in_flush  in  1  misbranch flush; drops all pending results
in_valid  in  N_REQ  per-unit result valid
out_ready  out  N_REQ  per-unit slot can accept this cycle
in_tag  in  N_REQ*TAG_W  per-unit ROB tag, unit i at bits [i*TAG_W +: TAG_W]
in_value  in  N_REQ*DATA_W  per-unit result value
in_isjump  in  N_REQ  per-unit branch-taken flag
in_jump_addr  in  N_REQ*DATA_W  per-unit jump target
in_rob_head  in  TAG_W  current ROB head tag (used only with CDB_AGE_PRIORITY_EN)
out_cdb_rob_tag  out  TAG_W  broadcast tag, 0 when idle
out_cdb_value  out  DATA_W  broadcast value
out_cdb_isjump  out  1  broadcast jump flag
out_cdb_jump_addr  out  DATA_W  broadcast jump address
out_busy  out  1  any slot occupied

Behaviour:
- Reset: all slots empty, RR pointer 0, out_cdb_rob_tag 0, value 0, isjump 0, jump_addr 0, out_busy 0.
- out_ready[i] = ena & !in_flush & (slot i empty | slot i granted this cycle). Combinational.
- Capture: on clk with in_valid[i] & out_ready[i] & in_tag[i] != 0, slot i loads the tag/value/isjump/addr. A request with tag 0 is accepted and discarded.
- Grant: round-robin among occupied slots, starting at the pointer. The winner is registered onto the CDB outputs at the same edge and its slot is freed. The pointer becomes winner+1, wrapping at N_REQ. With no occupied slot, out_cdb_rob_tag is 0 and the other CDB outputs are 0.
- Latency: a result captured at edge t broadcasts at edge t+1 at the earliest. Minimum per-unit throughput is 1 result every N_REQ cycles under full contention. A unit whose slot is granted may refill at the same edge, giving back-to-back operation.
- A newly captured result is never eligible in its capture cycle; the grant considers only pre-edge slot contents.
- Flush: at the edge with in_flush=1, all slots are cleared, CDB outputs go to 0, and the pointer is unchanged. Flush has priority over capture and grant.
- ena=0: slots, pointer and CDB outputs hold their values; nothing is captured or granted.
- out_busy = OR of slot valid bits (registered state).

Optional Feature:
CDB_AGE_PRIORITY_EN
- Defined: the grant goes to the occupied slot with the smallest ROB age, age = (tag >= in_rob_head) ? tag - in_rob_head : tag + ROB_SIZE - in_rob_head. Ties are broken by the lowest index. The pointer is still updated but unused.
- Undefined: pure round-robin as above; in_rob_head is ignored.

Decomposition:
- Shared constants package/header: ZERO_ROB (tag 0), TAG_W/DATA_W defaults, ROB_SIZE, TRUE/FALSE.
- One sub-module, rr_picker: inputs are the request vector and pointer; outputs are a one-hot grant and an index. Purely combinational, reusable by the LS-side bus.
- The age-compare logic stays inline under the macro.

Test Plan:
- Single unit: unit0 valid, tag 3, value 0x1234 at cycle 0 -> out_cdb_rob_tag=3 and value 0x1234 at cycle 1; tag 0 at cycle 2.
- Contention: units 0,1,2 valid in the same cycle with tags 1,2,3, pointer 0 -> broadcasts 1,2,3 on consecutive cycles; unit 0 ready each cycle after its grant.
- Fairness: unit0 valid every cycle (tags 4,5,...), unit1 valid once with tag 9 -> tag 9 broadcast within 2 cycles, never starved.
- Flush: 3 slots full, in_flush pulsed -> next cycle out_cdb_rob_tag=0, out_busy=0, and no stale tag ever broadcast.
- Tag 0 and ena: in_valid with tag 0 -> no broadcast. ena low for 3 cycles with full slots -> CDB outputs held and no grants; resume order unchanged.
- (macro on) head=14, ROB_SIZE=15, pending tags 2 and 15 -> tag 15 broadcast first.
